// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline stage register: valid/ready handshake with a one-entry skid
// buffer, synchronous flush to bubbles, and a saturating back-pressure counter.
module ex_mem_pipe_reg #(
  parameter int OPCODE_W    = 5,
  parameter int RD_W        = 9,
  parameter int BR_W        = 7,
  parameter int DATA_W      = 32,
  parameter logic [OPCODE_W-1:0] NOP_OPCODE = '0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_W-1:0]    in_opcode,
  input  logic [RD_W-1:0]        in_rd,
  input  logic [BR_W-1:0]        in_branch,
  input  logic [DATA_W-1:0]      in_alu,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPCODE_W-1:0]    out_opcode,
  output logic [RD_W-1:0]        out_rd,
  output logic [BR_W-1:0]        out_branch,
  output logic [DATA_W-1:0]      out_alu,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PW = OPCODE_W + RD_W + BR_W + DATA_W;

  logic [PW-1:0]          m_q, m_d, s_q, s_d, in_pl;
  logic                   m_v_q, m_v_d, s_v_q, s_v_d;
  logic                   rdy_q, rdy_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   in_xfer, out_xfer;

  logic [OPCODE_W-1:0]    m_opcode;
  logic [RD_W-1:0]        m_rd;
  logic [BR_W-1:0]        m_branch;
  logic [DATA_W-1:0]      m_alu;

  assign in_pl    = {in_opcode, in_rd, in_branch, in_alu};
  assign in_xfer  = in_valid & rdy_q;
  assign out_xfer = m_v_q & out_ready;

  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    if (flush) begin
      // Output transfer this cycle is still consumed by MEM; everything held dies.
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (out_xfer) begin
      if (s_v_q) begin
        m_d   = s_q;
        s_v_d = 1'b0;
      end else if (in_xfer) begin
        m_d   = in_pl;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!m_v_q) begin
        m_d   = in_pl;
        m_v_d = 1'b1;
      end else begin
        s_d   = in_pl;
        s_v_d = 1'b1;
      end
    end
    // Registered ready: reflects next-cycle skid occupancy, never out_ready.
    rdy_d = ~s_v_d;

    cnt_d = cnt_q;
    if (m_v_q && !out_ready && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      s_q   <= '0;
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      rdy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
    end
  end

  assign {m_opcode, m_rd, m_branch, m_alu} = m_q;

  // Bubbles are masked at the output so stale payload never leaks to MEM.
  assign in_ready   = rdy_q;
  assign out_valid  = m_v_q;
  assign out_opcode = m_v_q ? m_opcode : NOP_OPCODE;
  assign out_rd     = m_v_q ? m_rd     : '0;
  assign out_branch = m_v_q ? m_branch : '0;
  assign out_alu    = m_v_q ? m_alu    : '0;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: default instance plus a wide/narrow-counter
// instance, both compared each cycle against a two-entry queue model.
module tb_ex_mem_pipe_reg;

  typedef struct packed {
    logic [4:0]  op;
    logic [8:0]  rd;
    logic [6:0]  br;
    logic [63:0] alu;
  } ent_t;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [4:0]  op;
  logic [8:0]  rd;
  logic [6:0]  br;
  logic [63:0] alu;

  logic        a_ready, a_valid;
  logic [4:0]  a_op;
  logic [8:0]  a_rd;
  logic [6:0]  a_br;
  logic [31:0] a_alu;
  logic [15:0] a_sc;

  logic        b_ready, b_valid;
  logic [4:0]  b_op;
  logic [4:0]  b_rd;
  logic [6:0]  b_br;
  logic [63:0] b_alu;
  logic [3:0]  b_sc;

  int   n_chk = 0;
  int   n_fail = 0;
  ent_t q[$];
  int   sc_a, sc_b;
  bit   rdy_ok;

  ex_mem_pipe_reg dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_opcode(op), .in_rd(rd), .in_branch(br), .in_alu(alu[31:0]),
    .out_valid(a_valid), .out_ready(out_ready),
    .out_opcode(a_op), .out_rd(a_rd), .out_branch(a_br), .out_alu(a_alu),
    .stall_cnt(a_sc)
  );

  ex_mem_pipe_reg #(.DATA_W(64), .RD_W(5), .STALL_CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_ready),
    .in_opcode(op), .in_rd(rd[4:0]), .in_branch(br), .in_alu(alu),
    .out_valid(b_valid), .out_ready(out_ready),
    .out_opcode(b_op), .out_rd(b_rd), .out_branch(b_br), .out_alu(b_alu),
    .stall_cnt(b_sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    ent_t e;
    bit   v;
    bit   r;
    v = (q.size() > 0);
    e = v ? q[0] : '0;
    r = rdy_ok && (q.size() < 2);
    chk("a_ready", 64'(a_ready), 64'(r));
    chk("a_valid", 64'(a_valid), 64'(v));
    chk("a_op",    64'(a_op),    64'(e.op));
    chk("a_rd",    64'(a_rd),    64'(e.rd));
    chk("a_br",    64'(a_br),    64'(e.br));
    chk("a_alu",   64'(a_alu),   64'(e.alu[31:0]));
    chk("a_stall", 64'(a_sc),    64'(sc_a));
    chk("b_ready", 64'(b_ready), 64'(r));
    chk("b_valid", 64'(b_valid), 64'(v));
    chk("b_op",    64'(b_op),    64'(e.op));
    chk("b_rd",    64'(b_rd),    64'(e.rd[4:0]));
    chk("b_br",    64'(b_br),    64'(e.br));
    chk("b_alu",   b_alu,        e.alu);
    chk("b_stall", 64'(b_sc),    64'(sc_b));
  endtask

  // Reference: a FIFO of at most two entries; ready once out of reset and not full.
  task automatic step();
    bit   in_x, out_x;
    ent_t cur;
    cur   = '{op: op, rd: rd, br: br, alu: alu};
    in_x  = in_valid && rdy_ok && (q.size() < 2);
    out_x = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready) begin
      if (sc_a < 65535) sc_a++;
      if (sc_b < 15)    sc_b++;
    end
    if (flush) q.delete();
    else begin
      if (out_x) void'(q.pop_front());
      if (in_x)  q.push_back(cur);
    end
    rdy_ok = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit v, input bit ordy, input bit fl,
                       input logic [4:0] o, input logic [63:0] a);
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    op        = o;
    rd        = 9'(o) + 9'd3;
    br        = 7'(o) ^ 7'h55;
    alu       = a;
    step();
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_a_op",    64'(a_op),    64'd0);
    chk("rst_a_alu",   64'(a_alu),   64'd0);
    chk("rst_a_stall", 64'(a_sc),    64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_b_stall", 64'(b_sc),    64'd0);
    q.delete();
    sc_a   = 0;
    sc_b   = 0;
    rdy_ok = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    chk("rst_hold_ready", 64'(a_ready), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rd = '0; br = '0; alu = '0;
    sc_a = 0; sc_b = 0; rdy_ok = 1'b0;
    @(negedge clk);
    async_reset();

    // Streaming
    drive(1'b1, 1'b1, 1'b0, 5'd1, 64'h11);
    drive(1'b1, 1'b1, 1'b0, 5'd2, 64'h22);
    drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h33);
    chk("stream_last_alu", 64'(a_alu), 64'h33);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 64'd0);

    // Back-pressure: A into M, B into skid, then drain in order
    drive(1'b1, 1'b0, 1'b0, 5'd10, 64'hA);
    drive(1'b1, 1'b0, 1'b0, 5'd11, 64'hB);
    drive(1'b1, 1'b0, 1'b0, 5'd12, 64'hC);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
    chk("bp_second_is_b", 64'(a_alu), 64'hB);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 64'd0);

    // Flush with M and S full and a new input offered
    drive(1'b1, 1'b0, 1'b0, 5'd10, 64'hA);
    drive(1'b1, 1'b0, 1'b0, 5'd11, 64'hB);
    drive(1'b1, 1'b1, 1'b1, 5'd12, 64'hC);
    chk("flush_bubble", 64'(a_valid), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 64'd0);

    // Wide all-ones payload, then counter saturation on the 4-bit instance
    drive(1'b1, 1'b0, 1'b0, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wide_alu", b_alu, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("sat_b", 64'(b_sc), 64'd15);

    // Reset with both entries full
    drive(1'b1, 1'b0, 1'b0, 5'd7, 64'h77);
    async_reset();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0, 5'($urandom),
            {32'($urandom), 32'($urandom)});
      if (i == 200) async_reset();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
